lcd_refresh_sched: RTL

// - Owns a 4x20 character shadow buffer and schedules the hd44780 driver to

---
 rtl/lcd_refresh_sched.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/lcd_refresh_sched.sv
// Mirrors a 4x20 character shadow buffer onto an hd44780 driver via its cmd/vchr/busy handshake.
// Define LCD_CURSOR_TRACK_EN to skip redundant set-DDRAM-address commands on contiguous cells.
module lcd_refresh_sched #(
  parameter int POWERUP_CYCLES = 100_000_000,
  parameter int TIMEOUT_CYCLES = 10_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [1:0] wr_row,
  input  logic [4:0] wr_col,
  input  logic [7:0] wr_chr,
  input  logic       lcd_busy,
  output logic [1:0] lcd_cmd,
  output logic [8:0] lcd_vchr,
  output logic       ready,
  output logic       pending,
  output logic       err
);

  localparam logic [1:0] CMD_IDLE  = 2'd0;
  localparam logic [1:0] CMD_INIT  = 2'd1;
  localparam logic [1:0] CMD_WRITE = 2'd2;

  typedef enum logic [2:0] {
    PWRUP, INIT_REQ, INIT_WAIT, SCAN, ADDR_REQ, ADDR_WAIT, CHR_REQ, CHR_WAIT
  } state_t;

  state_t      state;
  logic [7:0]  buffer [80];
  logic [79:0] dirty;
  logic [1:0]  scan_row;
  logic [4:0]  scan_col;
  logic [6:0]  scan_idx;
  logic [6:0]  wr_idx;
  logic [6:0]  lat_idx;
  logic [7:0]  lat_chr;
  logic [31:0] pwr_cnt;
  logic [31:0] to_cnt;
  logic        req_state;
  logic        wait_state;
  logic        cell_state;
  logic        advance;
  logic        tmo;
  logic        pick;
`ifdef LCD_CURSOR_TRACK_EN
  logic [1:0]  lat_row;
  logic [4:0]  lat_col;
  logic        cur_valid;
  logic [1:0]  cur_row;
  logic [4:0]  cur_col;
`endif

  function automatic logic [7:0] row_base(input logic [1:0] r);
    case (r)
      2'd0:    return 8'h00;
      2'd1:    return 8'h40;
      2'd2:    return 8'h14;
      default: return 8'h54;
    endcase
  endfunction

  assign scan_idx   = 7'(scan_row) * 7'd20 + 7'(scan_col);
  assign wr_idx     = 7'(wr_row) * 7'd20 + 7'(wr_col);
  assign req_state  = (state == INIT_REQ) || (state == ADDR_REQ) || (state == CHR_REQ);
  assign wait_state = (state == INIT_WAIT) || (state == ADDR_WAIT) || (state == CHR_WAIT);
  assign cell_state = (state == ADDR_REQ) || (state == ADDR_WAIT) ||
                      (state == CHR_REQ) || (state == CHR_WAIT);
  assign advance    = (req_state && lcd_busy) || (wait_state && !lcd_busy);
  assign tmo        = (req_state || wait_state) && !advance &&
                      (to_cnt == 32'(TIMEOUT_CYCLES - 1));
  assign pick       = (state == SCAN) && dirty[scan_idx];
  assign pending    = |dirty;

  // Host set is applied last so it beats a same-cycle scheduler clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dirty <= '1;
      for (int i = 0; i < 80; i++) buffer[i] <= 8'h20;
    end else begin
      if (pick) dirty[scan_idx] <= 1'b0;
      if (tmo && cell_state) dirty[lat_idx] <= 1'b1;
      if (wr_en && (wr_col < 5'd20)) begin
        buffer[wr_idx] <= wr_chr;
        dirty[wr_idx]  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= PWRUP;
      lcd_cmd   <= CMD_IDLE;
      lcd_vchr  <= '0;
      ready     <= 1'b0;
      err       <= 1'b0;
      pwr_cnt   <= '0;
      to_cnt    <= '0;
      scan_row  <= '0;
      scan_col  <= '0;
      lat_idx   <= '0;
      lat_chr   <= '0;
`ifdef LCD_CURSOR_TRACK_EN
      lat_row   <= '0;
      lat_col   <= '0;
      cur_valid <= 1'b0;
      cur_row   <= '0;
      cur_col   <= '0;
`endif
    end else if (tmo) begin
      err     <= 1'b1;
      lcd_cmd <= CMD_IDLE;
      to_cnt  <= '0;
      state   <= ((state == INIT_REQ) || (state == INIT_WAIT)) ? INIT_REQ : SCAN;
`ifdef LCD_CURSOR_TRACK_EN
      cur_valid <= 1'b0;
`endif
    end else begin
      to_cnt <= to_cnt + 32'd1;
      case (state)
        PWRUP: begin
          if (pwr_cnt == 32'(POWERUP_CYCLES - 1)) begin
            state    <= INIT_REQ;
            lcd_cmd  <= CMD_INIT;
            lcd_vchr <= '0;
            to_cnt   <= '0;
          end else begin
            pwr_cnt <= pwr_cnt + 32'd1;
          end
        end
        INIT_REQ: begin
          if (lcd_busy) begin
            state   <= INIT_WAIT;
            lcd_cmd <= CMD_IDLE;
            to_cnt  <= '0;
          end else begin
            lcd_cmd <= CMD_INIT;
          end
        end
        INIT_WAIT: begin
          if (!lcd_busy) begin
            state <= SCAN;
            ready <= 1'b1;
          end
        end
        SCAN: begin
          to_cnt <= '0;
          if (scan_col == 5'd19) begin
            scan_col <= '0;
            scan_row <= scan_row + 2'd1;
          end else begin
            scan_col <= scan_col + 5'd1;
          end
          if (dirty[scan_idx]) begin
            lat_idx <= scan_idx;
            lat_chr <= buffer[scan_idx];
            lcd_cmd <= CMD_WRITE;
`ifdef LCD_CURSOR_TRACK_EN
            lat_row <= scan_row;
            lat_col <= scan_col;
            if (cur_valid && (cur_row == scan_row) && (cur_col == scan_col)) begin
              state    <= CHR_REQ;
              lcd_vchr <= {1'b0, buffer[scan_idx]};
            end else begin
              state     <= ADDR_REQ;
              lcd_vchr  <= {1'b1, 8'h80 | (row_base(scan_row) + {3'b000, scan_col})};
              cur_valid <= 1'b0;
            end
`else
            state    <= ADDR_REQ;
            lcd_vchr <= {1'b1, 8'h80 | (row_base(scan_row) + {3'b000, scan_col})};
`endif
          end
        end
        ADDR_REQ: begin
          if (lcd_busy) begin
            state   <= ADDR_WAIT;
            lcd_cmd <= CMD_IDLE;
            to_cnt  <= '0;
          end
        end
        ADDR_WAIT: begin
          if (!lcd_busy) begin
            state    <= CHR_REQ;
            lcd_cmd  <= CMD_WRITE;
            lcd_vchr <= {1'b0, lat_chr};
            to_cnt   <= '0;
          end
        end
        CHR_REQ: begin
          if (lcd_busy) begin
            state   <= CHR_WAIT;
            lcd_cmd <= CMD_IDLE;
            to_cnt  <= '0;
          end
        end
        CHR_WAIT: begin
          if (!lcd_busy) begin
            state <= SCAN;
`ifdef LCD_CURSOR_TRACK_EN
            // DDRAM is not contiguous across rows, so the cursor is only trusted mid-row.
            cur_valid <= (lat_col != 5'd19);
            cur_row   <= lat_row;
            cur_col   <= lat_col + 5'd1;
`endif
          end
        end
      endcase
    end
  end

endmodule
